// File: rtl/bcd_disp_pkg.sv
// rtl/bcd_disp_pkg.sv - segment codes and digit-select encodings for the BCD display scanner
package bcd_disp_pkg;

    // Active-high segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        DIG_ONES = 1'b0,
        DIG_TENS = 1'b1
    } dig_sel_e;

endpackage

// File: rtl/bcd_display_scanner_seg7_decoder.sv
// rtl/bcd_display_scanner_seg7_decoder.sv - BCD digit to active-high 7-segment code
module seg7_decoder
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] code
);

    always_comb begin
        code = SEG_DASH;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - latches a BCD result and scans it onto a 2-digit multiplexed 7-segment display
module bcd_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit BLANK_LZ       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       valid,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    dig_sel_e         sel;
    dig_sel_e         sel_next;

    logic [3:0] shadow_tens;
    logic [3:0] shadow_ones;
    logic       shadow_valid;

    logic [3:0] digit;
    logic [6:0] dec_code;
    logic [6:0] code;
    logic [6:0] seg_next;
    logic [1:0] an_next;
    logic       frame_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_tens  <= 4'd0;
            shadow_ones  <= 4'd0;
            shadow_valid <= 1'b0;
        end else if (load) begin
            shadow_tens  <= tens;
            shadow_ones  <= ones;
            shadow_valid <= valid && (tens <= 4'd9) && (ones <= 4'd9);
        end
    end

    // Scan state: the digit select flips each time the refresh counter wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            sel <= DIG_ONES;
        end else begin
            cnt <= cnt_next;
            sel <= sel_next;
        end
    end

    always_comb begin
        cnt_next = cnt + CNT_W'(1);
        sel_next = sel;
        if (cnt == CNT_LAST) begin
            cnt_next = '0;
            sel_next = (sel == DIG_ONES) ? DIG_TENS : DIG_ONES;
        end
    end

    assign digit = (sel == DIG_TENS) ? shadow_tens : shadow_ones;

    seg7_decoder u_dec (
        .digit (digit),
        .code  (dec_code)
    );

    // The tens anode stays enabled while blanked so the duty cycle is unchanged
    always_comb begin
        code = dec_code;
        if (!shadow_valid) begin
            code = SEG_DASH;
        end else if (BLANK_LZ && (sel == DIG_TENS) && (shadow_tens == 4'd0)) begin
            code = SEG_BLANK;
        end
        seg_next   = SEG_ACTIVE_LOW ? ~code : code;
        an_next    = (sel == DIG_ONES) ? 2'b10 : 2'b01;
        frame_next = (sel == DIG_ONES) && (an == 2'b01);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg   <= SEG_OFF;
            an    <= 2'b11;
            frame <= 1'b0;
        end else begin
            seg   <= seg_next;
            an    <= an_next;
            frame <= frame_next;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - scoreboard bench for bcd_display_scanner with three parameter variants
module tb_bcd_display_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [3:0] tens = 4'd0;
    logic [3:0] ones = 4'd0;
    logic       valid = 1'b0;

    logic [6:0] seg_m, seg_n, seg_a;
    logic [1:0] an_m, an_n, an_a;
    logic       frame_m, frame_n, frame_a;

    always #5 clk = ~clk;

    bcd_display_scanner #(.REFRESH_DIV(4), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b0)) dut_m (
        .clk(clk), .rst(rst), .load(load), .tens(tens), .ones(ones), .valid(valid),
        .seg(seg_m), .an(an_m), .frame(frame_m)
    );

    bcd_display_scanner #(.REFRESH_DIV(4), .BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut_n (
        .clk(clk), .rst(rst), .load(load), .tens(tens), .ones(ones), .valid(valid),
        .seg(seg_n), .an(an_n), .frame(frame_n)
    );

    bcd_display_scanner #(.REFRESH_DIV(4), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst(rst), .load(load), .tens(tens), .ones(ones), .valid(valid),
        .seg(seg_a), .an(an_a), .frame(frame_a)
    );

    typedef struct {
        logic [1:0] an;
        logic       frame;
        logic [6:0] seg_m;
        logic [6:0] seg_n;
        logic [6:0] seg_a;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   k = 0;

    // Expected {ones, tens} codes per variant for the currently latched value
    logic [6:0] co_m = 7'h40, ct_m = 7'h40;
    logic [6:0] co_n = 7'h40, ct_n = 7'h40;
    logic [6:0] co_a = 7'h3F, ct_a = 7'h3F;

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle_k=%0d actual=%h expected=%h", name, k, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("an_m",    {5'd0, an_m},    {5'd0, mon_e.an});
            chk("an_n",    {5'd0, an_n},    {5'd0, mon_e.an});
            chk("an_a",    {5'd0, an_a},    {5'd0, mon_e.an});
            chk("frame_m", {6'd0, frame_m}, {6'd0, mon_e.frame});
            chk("frame_a", {6'd0, frame_a}, {6'd0, mon_e.frame});
            chk("seg_m",   seg_m,           mon_e.seg_m);
            chk("seg_n",   seg_n,           mon_e.seg_n);
            chk("seg_a",   seg_a,           mon_e.seg_a);
        end
    end

    task automatic step(input logic r, input logic ld, input logic [3:0] t,
                        input logic [3:0] o, input logic v);
        exp_t e;
        logic tens_ph;
        rst = r; load = ld; tens = t; ones = o; valid = v;
        @(posedge clk);
        #1;
        if (r) begin
            e.an = 2'b11; e.frame = 1'b0;
            e.seg_m = 7'h00; e.seg_n = 7'h00; e.seg_a = 7'h7F;
            k = 0;
            co_m = 7'h40; ct_m = 7'h40; co_n = 7'h40; ct_n = 7'h40;
            co_a = 7'h3F; ct_a = 7'h3F;
        end else begin
            tens_ph = ((k / 4) % 2) == 1;
            e.an    = tens_ph ? 2'b01 : 2'b10;
            e.frame = (k > 0) && (k % 8 == 0);
            e.seg_m = tens_ph ? ct_m : co_m;
            e.seg_n = tens_ph ? ct_n : co_n;
            e.seg_a = tens_ph ? ct_a : co_a;
            k++;
        end
        sb.push_back(e);
        rst = 1'b0; load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic ld(input logic [3:0] t, input logic [3:0] o, input logic v,
                      input logic [6:0] om, input logic [6:0] tm,
                      input logic [6:0] on, input logic [6:0] tn,
                      input logic [6:0] oa, input logic [6:0] ta);
        step(1'b0, 1'b1, t, o, v);
        co_m = om; ct_m = tm; co_n = on; ct_n = tn; co_a = oa; ct_a = ta;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        idle(16);
        ld(4'd0, 4'd7, 1'b1, 7'h07, 7'h00, 7'h07, 7'h3F, 7'h78, 7'h7F);
        idle(15);
        ld(4'd1, 4'd5, 1'b1, 7'h6D, 7'h06, 7'h6D, 7'h06, 7'h12, 7'h79);
        idle(15);
        ld(4'd0, 4'hC, 1'b1, 7'h40, 7'h40, 7'h40, 7'h40, 7'h3F, 7'h3F);
        idle(7);
        ld(4'd1, 4'd5, 1'b1, 7'h6D, 7'h06, 7'h6D, 7'h06, 7'h12, 7'h79);
        idle(7);
        ld(4'd0, 4'd3, 1'b0, 7'h40, 7'h40, 7'h40, 7'h40, 7'h3F, 7'h3F);
        idle(7);
        ld(4'd2, 4'd3, 1'b1, 7'h4F, 7'h5B, 7'h4F, 7'h5B, 7'h30, 7'h24);
        idle(7);
        ld(4'd6, 4'd4, 1'b1, 7'h66, 7'h7D, 7'h66, 7'h7D, 7'h19, 7'h02);
        idle(7);
        ld(4'd8, 4'd0, 1'b1, 7'h3F, 7'h7F, 7'h3F, 7'h7F, 7'h40, 7'h00);
        idle(9);
        // k = 98: third cycle of a ones phase
        ld(4'd9, 4'd9, 1'b1, 7'h6F, 7'h6F, 7'h6F, 7'h6F, 7'h10, 7'h10);
        idle(5);
        idle(5);
        // k = 109 falls in a tens phase
        step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        idle(10);
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0", sb.size());
        end
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
